rotate_cmd_sequencer: RTL and testbench

ROTATE_CMD_SEQUENCER -- requirements
Module: rotate_cmd_sequencer

---
 rtl/rotseq_pkg.sv | 23 ++
 rtl/rotseq_cmd_fifo.sv | 65 ++++++
 rtl/rotate_cmd_sequencer.sv | 157 +++++++++++++++
 tb/tb_rotate_cmd_sequencer.sv | 299 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rotseq_pkg.sv
// Shared opcode/state types for the rotate command sequencer and its FIFO.
package rotseq_pkg;

    localparam int unsigned OP_W = 2;

    typedef enum logic [OP_W-1:0] {
        OP_NOP  = 2'b00,
        OP_LOAD = 2'b01,
        OP_ROTL = 2'b10,
        OP_ROTR = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    function automatic logic is_rotate(input op_e op);
        return (op == OP_ROTL) || (op == OP_ROTR);
    endfunction

endpackage

// File: rtl/rotseq_cmd_fifo.sv
// Command FIFO for the rotate sequencer; DEPTH must be a power of two.
// With ROTSEQ_ABORT_EN defined a flush input empties the FIFO.
module rotseq_cmd_fifo #(
    parameter int unsigned WIDTH = 10,
    parameter int unsigned DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
`ifdef ROTSEQ_ABORT_EN
    input  logic             flush,
`endif
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic             full,
    output logic             empty
);

    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [CW-1:0]    count;
    logic             do_push;
    logic             do_pop;

    assign do_push  = push && !full;
    assign do_pop   = pop && !empty;
    assign full     = (count == CW'(DEPTH));
    assign empty    = (count == '0);
    assign pop_data = mem[rd_ptr];

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end
`ifdef ROTSEQ_ABORT_EN
        else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end
`endif
        else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/rotate_cmd_sequencer.sv
// Queues LOAD/ROTL/ROTR/NOP commands and drives a downstream rotator.
// Optional abort port and flush logic when ROTSEQ_ABORT_EN is defined.
module rotate_cmd_sequencer
    import rotseq_pkg::*;
#(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
`ifdef ROTSEQ_ABORT_EN
    input  logic             abort,
`endif
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [1:0]       cmd_op,
    input  logic [WIDTH-1:0] cmd_arg,
    output logic             enable,
    output logic             load,
    output logic             dir,
    output logic [WIDTH-1:0] data_in,
    output logic             busy,
    output logic             done
);

    localparam int unsigned FW = OP_W + WIDTH;

    state_e           state, state_nxt;
    op_e              cur_op;
    logic [WIDTH-1:0] cur_arg;
    logic [WIDTH-1:0] step_cnt;
    logic             fifo_full, fifo_empty, fifo_push, fifo_pop;
    logic [FW-1:0]    fifo_head;
    logic             enable_nxt, load_nxt, dir_nxt, busy_nxt, done_nxt;
    logic [WIDTH-1:0] data_in_nxt;

`ifdef ROTSEQ_ABORT_EN
    assign cmd_ready = !fifo_full && !abort;
`else
    assign cmd_ready = !fifo_full;
`endif
    assign fifo_push = cmd_valid && cmd_ready;

    rotseq_cmd_fifo #(
        .WIDTH (FW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
`ifdef ROTSEQ_ABORT_EN
        .flush     (abort),
`endif
        .push      (fifo_push),
        .push_data ({cmd_op, cmd_arg}),
        .pop       (fifo_pop),
        .pop_data  (fifo_head),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) state <= ST_IDLE;
        else        state <= state_nxt;
    end

    // A rotate of N>0 stays in EXEC until its last step; everything else takes one cycle.
    always_comb begin
        state_nxt = state;
        fifo_pop  = 1'b0;
        case (state)
            ST_IDLE: begin
                if (!fifo_empty) begin
                    fifo_pop  = 1'b1;
                    state_nxt = ST_EXEC;
                end
            end
            ST_EXEC: begin
                if (!is_rotate(cur_op) || (step_cnt <= WIDTH'(1))) state_nxt = ST_DONE;
            end
            ST_DONE: state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
`ifdef ROTSEQ_ABORT_EN
        if (abort) begin
            state_nxt = ST_IDLE;
            fifo_pop  = 1'b0;
        end
`endif
    end

    // Next values of the registered rotator controls; dir/data_in hold between commands.
    always_comb begin
        enable_nxt  = 1'b0;
        load_nxt    = 1'b0;
        dir_nxt     = dir;
        data_in_nxt = data_in;
        done_nxt    = 1'b0;
        busy_nxt    = (state != ST_IDLE);
        case (state)
            ST_EXEC: begin
                if (cur_op == OP_LOAD) begin
                    enable_nxt  = 1'b1;
                    load_nxt    = 1'b1;
                    data_in_nxt = cur_arg;
                end else if (is_rotate(cur_op) && (step_cnt != '0)) begin
                    enable_nxt = 1'b1;
                    dir_nxt    = (cur_op == OP_ROTR);
                end
            end
            ST_DONE: done_nxt = 1'b1;
            default: ;
        endcase
`ifdef ROTSEQ_ABORT_EN
        if (abort) begin
            enable_nxt  = 1'b0;
            load_nxt    = 1'b0;
            dir_nxt     = dir;
            data_in_nxt = data_in;
            done_nxt    = 1'b0;
            busy_nxt    = 1'b0;
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            enable  <= 1'b0;
            load    <= 1'b0;
            dir     <= 1'b0;
            data_in <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            enable  <= enable_nxt;
            load    <= load_nxt;
            dir     <= dir_nxt;
            data_in <= data_in_nxt;
            busy    <= busy_nxt;
            done    <= done_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cur_op   <= OP_NOP;
            cur_arg  <= '0;
            step_cnt <= '0;
        end else if (fifo_pop) begin
            cur_op   <= op_e'(fifo_head[FW-1:WIDTH]);
            cur_arg  <= fifo_head[WIDTH-1:0];
            step_cnt <= fifo_head[WIDTH-1:0];
        end else if ((state == ST_EXEC) && (step_cnt != '0)) begin
            step_cnt <= step_cnt - WIDTH'(1);
        end
    end

endmodule

// File: tb/tb_rotate_cmd_sequencer.sv
// Bench for rotate_cmd_sequencer: schedule-based output model plus a downstream rotator.
module tb_rotate_cmd_sequencer;

    localparam int DEPTH = 4;
    localparam int N     = 1024;

    logic       clk;
    logic       rst_n;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [1:0] cmd_op;
    logic [7:0] cmd_arg;
    logic       enable, load, dir, busy, done;
    logic [7:0] data_in;
    bit         abort_sig;

    rotate_cmd_sequencer #(.WIDTH(8), .DEPTH(DEPTH)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
`ifdef ROTSEQ_ABORT_EN
        .abort     (abort_sig),
`endif
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_op    (cmd_op),
        .cmd_arg   (cmd_arg),
        .enable    (enable),
        .load      (load),
        .dir       (dir),
        .data_in   (data_in),
        .busy      (busy),
        .done      (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s @%0t: got %0h expected %0h", nm, $time, act, exp);
        end
    endtask

    // Expected outputs indexed by the edge after which they are visible.
    bit       e_en[N], e_ld[N], e_busy[N], e_done[N], e_rst[N];
    bit       e_dirv[N], e_dir[N], e_datv[N];
    bit [7:0] e_data[N];
    int       q_acc[$], q_pop[$];
    bit       q_vld[$];
    int       last_done = -100;
    int       cyc = 0;
    bit       started = 1'b0;
    bit       m_dir;
    bit [7:0] m_data;

    function automatic int occ(input int e);
        int n = 0;
        foreach (q_acc[i]) if (q_vld[i] && q_acc[i] < e && q_pop[i] >= e) n++;
        return n;
    endfunction

    // A command waits for edge t+1 and for the IDLE edge after the previous done, executes, then pulses done.
    function automatic void schedule(input int t, input logic [1:0] op, input logic [7:0] arg);
        int p, start, len, d;
        p     = (t + 1 > last_done + 1) ? t + 1 : last_done + 1;
        start = p + 1;
        len   = ((op == 2'd2 || op == 2'd3) && arg != 8'd0) ? int'(arg) : 1;
        d     = start + len;
        for (int k = start; k < d && k < N; k++) begin
            e_busy[k] = 1'b1;
            if (op == 2'd1) begin
                e_en[k] = 1'b1; e_ld[k] = 1'b1; e_datv[k] = 1'b1; e_data[k] = arg;
            end else if (len > 1 || (op[1] && arg != 8'd0)) begin
                e_en[k] = 1'b1; e_dirv[k] = 1'b1; e_dir[k] = (op == 2'd3);
            end
        end
        if (d < N) begin
            e_busy[d] = 1'b1;
            e_done[d] = 1'b1;
        end
        last_done = d;
        q_acc.push_back(t);
        q_pop.push_back(p);
        q_vld.push_back(1'b1);
    endfunction

    function automatic void flush_model(input int r, input bit is_rst);
        foreach (q_pop[i]) if (q_pop[i] >= r) q_vld[i] = 1'b0;
        for (int k = r; k < N; k++) begin
            e_en[k] = 0; e_ld[k] = 0; e_busy[k] = 0; e_done[k] = 0;
            e_dirv[k] = 0; e_datv[k] = 0; e_rst[k] = 0;
        end
        if (is_rst && r < N) e_rst[r] = 1'b1;
        last_done = -100;
    endfunction

    always @(posedge clk) begin
        cyc++;
        if (!rst_n) begin
            flush_model(cyc, 1'b1);
            started = 1'b1;
        end else if (abort_sig) begin
            flush_model(cyc, 1'b0);
        end else if (started && cmd_valid && occ(cyc) < DEPTH) begin
            schedule(cyc, cmd_op, cmd_arg);
        end
    end

    // Downstream rotator and per-test window counters.
    bit [7:0] rot = 8'h00;
    int en_cnt, ld_cnt, done_cnt, rotl_cnt, rotr_cnt, first_en;
    int stall;

    always @(negedge clk) begin
        if (started && cyc < N) begin
            if (e_rst[cyc]) begin m_dir = 1'b0; m_data = 8'h00; end
            if (e_dirv[cyc]) m_dir = e_dir[cyc];
            if (e_datv[cyc]) m_data = e_data[cyc];
            chk("enable", enable, e_en[cyc]);
            chk("load", load, e_ld[cyc]);
            chk("busy", busy, e_busy[cyc]);
            chk("done", done, e_done[cyc]);
            chk("dir", dir, m_dir);
            chk("data_in", data_in, m_data);
            chk("cmd_ready", cmd_ready, (occ(cyc + 1) < DEPTH) && !abort_sig);
            if (enable === 1'b1) begin
                if (first_en < 0) first_en = cyc;
                if (load === 1'b1) begin
                    ld_cnt++;
                    rot = data_in;
                end else begin
                    en_cnt++;
                    if (dir === 1'b1) begin rotr_cnt++; rot = {rot[0], rot[7:1]}; end
                    else              begin rotl_cnt++; rot = {rot[6:0], rot[7]}; end
                end
            end
            if (done === 1'b1) done_cnt++;
        end
    end

    task automatic clr_win();
        en_cnt = 0; ld_cnt = 0; done_cnt = 0; rotl_cnt = 0; rotr_cnt = 0;
        first_en = -1; stall = 0;
    endtask

    // Called at posedge+#1; returns at posedge+#1 after the accepting edge.
    task automatic push(input logic [1:0] op, input logic [7:0] arg, output int acc);
        bit ok = 1'b0;
        acc = -1;
        cmd_valid = 1'b1; cmd_op = op; cmd_arg = arg;
        for (int i = 0; i < 500 && !ok; i++) begin
            @(negedge clk);
            ok = (cmd_ready === 1'b1);
            @(posedge clk); #1;
            if (ok) acc = cyc;
            else    stall++;
        end
        cmd_valid = 1'b0;
        if (!ok) begin
            n_cmp++; n_bad++;
            $display("FAIL push_timeout: op %0d arg %0h never accepted", op, arg);
        end
    endtask

    task automatic wait_idle();
        bit ok = 1'b0;
        for (int i = 0; i < 800 && !ok; i++) begin
            @(negedge clk);
            if (cyc >= last_done + 2 && occ(cyc + 1) == 0) ok = 1'b1;
        end
        @(posedge clk); #1;
        if (!ok) begin
            n_cmp++; n_bad++;
            $display("FAIL idle_timeout: sequencer still busy at cycle %0d", cyc);
        end
    endtask

    task automatic wait_enables(input int n);
        int seen = 0;
        for (int i = 0; i < 300 && seen < n; i++) begin
            @(negedge clk);
            if (enable === 1'b1) seen++;
        end
        if (seen < n) begin
            n_cmp++; n_bad++;
            $display("FAIL enable_timeout: saw %0d enables, wanted %0d", seen, n);
        end
        @(posedge clk); #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int a;
        rst_n = 1'b0; cmd_valid = 1'b0; cmd_op = 2'd0; cmd_arg = 8'h00; abort_sig = 1'b0;
        clr_win();
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        chk("rst_busy", busy, 1'b0);
        chk("rst_enable", enable, 1'b0);
        chk("rst_ready", cmd_ready, 1'b1);
        chk("rst_data", data_in, 8'h00);

        // LOAD 0x12
        clr_win();
        push(2'd1, 8'h12, a);
        wait_idle();
        chk("t1_latency", first_en - a, 2);
        chk("t1_loads", ld_cnt, 1);
        chk("t1_done", done_cnt, 1);
        chk("t1_rot", rot, 8'h12);

        // LOAD 0x01 then ROTL 8
        clr_win();
        push(2'd1, 8'h01, a);
        push(2'd2, 8'd8, a);
        wait_idle();
        chk("t2_rotl", rotl_cnt, 8);
        chk("t2_rotr", rotr_cnt, 0);
        chk("t2_done", done_cnt, 2);
        chk("t2_rot", rot, 8'h01);

        // ROTR 0 and NOP
        clr_win();
        push(2'd3, 8'd0, a);
        push(2'd0, 8'h5A, a);
        wait_idle();
        chk("t3_enables", en_cnt + ld_cnt, 0);
        chk("t3_done", done_cnt, 2);

        // Fill the FIFO behind ROTL 20
        clr_win();
        push(2'd2, 8'd20, a);
        push(2'd1, 8'h0F, a);
        push(2'd3, 8'd4, a);
        push(2'd2, 8'd1, a);
        push(2'd0, 8'h00, a);
        chk("t4_full", cmd_ready, 1'b0);
        push(2'd3, 8'd3, a);
        chk("t4_stalled", stall > 0, 1'b1);
        wait_idle();
        chk("t4_done", done_cnt, 6);
        chk("t4_rot", rot, 8'h3C);

        // Reset in the middle of ROTR 10
        clr_win();
        push(2'd3, 8'd10, a);
        wait_enables(2);
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        chk("t5_enables", en_cnt, 3);
        chk("t5_done", done_cnt, 0);
        chk("t5_busy", busy, 1'b0);
        chk("t5_ready", cmd_ready, 1'b1);
        chk("t5_rot", rot, 8'h87);
        clr_win();
        push(2'd1, 8'h81, a);
        wait_idle();
        chk("t5_fifo_empty_done", done_cnt, 1);
        chk("t5_rot_after", rot, 8'h81);

`ifdef ROTSEQ_ABORT_EN
        // Abort ROTL 10 with two commands queued
        clr_win();
        push(2'd2, 8'd10, a);
        push(2'd1, 8'hAA, a);
        push(2'd3, 8'd1, a);
        wait_enables(3);
        abort_sig = 1'b1;
        chk("t6_ready_in_abort", cmd_ready, 1'b0);
        @(posedge clk); #1;
        abort_sig = 1'b0;
        chk("t6_ready_after", cmd_ready, 1'b1);
        repeat (30) @(posedge clk);
        #1;
        chk("t6_enables", en_cnt, 4);
        chk("t6_loads", ld_cnt, 0);
        chk("t6_done", done_cnt, 0);
        chk("t6_rot", rot, 8'h18);
`endif

        repeat (2) @(posedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
